seq_det_sched: RTL and testbench

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

---
 rtl/seq_det_sched_pkg.sv | 38 +++
 rtl/seq_det_core.sv | 48 ++++
 rtl/seq_det_sched.sv | 169 ++++++++++++++++
 tb/tb_seq_det_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_sched_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_sched_pkg
//
// Shared definitions for the time-multiplexed sequence detector.
//   det_state_t : 2-bit detector context encoding (S0..S3). One context is
//                 stored per requester channel; the single shared core reads
//                 and updates whichever context belongs to the granted channel.
//   NCH_*       : legal bounds for the channel count (2, 4 or 8 channels).
//   CW_*        : legal bounds for the per-channel match counter width.
// ---------------------------------------------------------------------------
package seq_det_sched_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } det_state_t;

   // The round-robin pointer wraps by plain binary overflow, so the channel
   // count has to be a power of two inside these bounds.
   localparam int NCH_MIN = 2;
   localparam int NCH_MAX = 8;

   localparam int CW_MIN = 1;
   localparam int CW_MAX = 32;

   // True for a channel count the scheduler supports.
   function automatic bit nch_is_legal(input int n);
      return (n == 2) || (n == 4) || (n == 8);
   endfunction

   // True for a counter width the scheduler supports.
   function automatic bit cw_is_legal(input int w);
      return (w >= CW_MIN) && (w <= CW_MAX);
   endfunction

endpackage

// File: rtl/seq_det_core.sv
// ---------------------------------------------------------------------------
// seq_det_core
//
// Purely combinational detector step. Given the stored context of one
// channel and that channel's serial bit, it returns the context to store
// back and the Mealy match output for this bit.
//
// Ports:
//   state      in   det_state_t  context of the channel being served
//   din        in   1            serial bit being consumed
//   next_state out  det_state_t  context after consuming din
//   dout       out  1            match output for (state, din)
// ---------------------------------------------------------------------------
module seq_det_core
   import seq_det_sched_pkg::*;
(
   input  det_state_t state,
   input  logic       din,
   output det_state_t next_state,
   output logic       dout
);

   always_comb begin
      next_state = S0;
      dout       = 1'b0;
      unique case (state)
         S0: begin
            next_state = din ? S3 : S2;
         end
         S1: begin
            next_state = din ? S3 : S2;
            dout       = ~din;
         end
         S2: begin
            next_state = din ? S3 : S0;
            dout       = din;
         end
         S3: begin
            next_state = din ? S1 : S2;
         end
         default: begin
            next_state = S0;
            dout       = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_det_sched.sv
// ---------------------------------------------------------------------------
// seq_det_sched
//
// NCH serial requesters share a single sequence-detector core. A round-robin
// arbiter picks one eligible channel per cycle; the core processes that
// channel's bit against the channel's stored 2-bit context, the context is
// written back, a registered match pulse is raised for the channel, and the
// channel's saturating match counter is bumped when the core fires.
//
// Handshake: req[ch] is a request to consume one bit. The requester holds
// req[ch] and bit_in[ch] stable until the rising edge where gnt[ch] is high;
// that edge consumes the bit. Dropping req before a grant withdraws the bit
// without side effects. ctx_clr[ch] masks the channel from arbitration for
// the cycle and returns its context to S0 at the edge.
//
// Ports:
//   clk      in   1          clock, all state changes on posedge
//   reset    in   1          asynchronous active-high reset
//   req      in   NCH        per-channel request
//   bit_in   in   NCH        per-channel serial bit, valid with req
//   ctx_clr  in   NCH        per-channel context clear (level, synchronous)
//   cnt_clr  in   1          clears every match counter (synchronous)
//   cnt_sel  in   log2(NCH)  channel shown on cnt_out
//   gnt      out  NCH        one-hot grant, combinational
//   match    out  NCH        registered one-cycle match pulse
//   cnt_out  out  CW         counter of channel cnt_sel, combinational
//   ctx_dbg  out  2*NCH      packed per-channel contexts (ch0 in bits 1:0)
// ---------------------------------------------------------------------------
module seq_det_sched
   import seq_det_sched_pkg::*;
#(
   parameter  int NCH = 4,
   parameter  int CW  = 8,
   localparam int SW  = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    bit_in,
   input  logic [NCH-1:0]    ctx_clr,
   input  logic              cnt_clr,
   input  logic [SW-1:0]     cnt_sel,
   output logic [NCH-1:0]    gnt,
   output logic [NCH-1:0]    match,
   output logic [CW-1:0]     cnt_out,
   output logic [2*NCH-1:0]  ctx_dbg
);

   localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   det_state_t    ctx [NCH];
   logic [CW-1:0] cnt [NCH];
   logic [SW-1:0] last_gnt;

   // ------------------------------------------------------------------
   // Arbiter
   // ------------------------------------------------------------------
   logic [NCH-1:0] elig;
   logic [SW-1:0]  cand;
   logic [SW-1:0]  gnt_idx;
   logic           gnt_any;

   // Search starts one past the last granted channel. NCH is a power of
   // two, so last_gnt + k wraps modulo NCH for free; k = NCH lands back on
   // last_gnt itself, which is the last candidate in the rotation.
   always_comb begin
      elig    = req & ~ctx_clr;
      cand    = last_gnt;
      gnt_idx = last_gnt;
      gnt_any = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         cand = last_gnt + SW'(k);
         if (!gnt_any && elig[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Shared detector core, fed by the granted channel
   // ------------------------------------------------------------------
   det_state_t core_state;
   det_state_t core_next;
   logic       core_in;
   logic       core_out;
   logic       fire;

   // When nothing is granted the core still evaluates channel last_gnt;
   // that result is discarded because every update is qualified by gnt_any.
   assign core_state = ctx[gnt_idx];
   assign core_in    = bit_in[gnt_idx];
   assign fire       = gnt_any & core_out;

   seq_det_core u_core (
      .state      (core_state),
      .din        (core_in),
      .next_state (core_next),
      .dout       (core_out)
   );

   // ------------------------------------------------------------------
   // Contexts, pointer and match pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int ch = 0; ch < NCH; ch++) begin
            ctx[ch] <= S0;
         end
         last_gnt <= LAST_CH;
         match    <= '0;
      end else begin
         // gnt is one-hot, so gating it with fire gives the pulse vector and
         // clears every bit when no match happens this cycle.
         match <= fire ? gnt : '0;
         if (gnt_any) begin
            last_gnt <= gnt_idx;
         end
         // A cleared channel is never granted, so the two branches below
         // never compete for the same context.
         for (int ch = 0; ch < NCH; ch++) begin
            if (ctx_clr[ch]) begin
               ctx[ch] <= S0;
            end else if (gnt_any && (gnt_idx == SW'(ch))) begin
               ctx[ch] <= core_next;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Saturating match counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int ch = 0; ch < NCH; ch++) begin
            cnt[ch] <= '0;
         end
      end else if (cnt_clr) begin
         // Clear wins over an increment landing on the same edge.
         for (int ch = 0; ch < NCH; ch++) begin
            cnt[ch] <= '0;
         end
      end else if (fire && (cnt[gnt_idx] != CNT_MAX)) begin
         cnt[gnt_idx] <= cnt[gnt_idx] + CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Read-out
   // ------------------------------------------------------------------
   assign cnt_out = cnt[cnt_sel];

   for (genvar g = 0; g < NCH; g++) begin : g_dbg
      assign ctx_dbg[2*g +: 2] = ctx[g];
   end

endmodule

// File: tb/tb_seq_det_sched.sv
module tb_seq_det_sched;
   import seq_det_sched_pkg::*;

   localparam int NCH  = 4;
   localparam int CW   = 8;
   localparam int SW   = 2;
   localparam int W    = 32 + NCH;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [NCH-1:0]   req, bit_in, ctx_clr;
   logic             cnt_clr;
   logic [SW-1:0]    cnt_sel;
   logic [NCH-1:0]   gnt, match;
   logic [CW-1:0]    cnt_out;
   logic [2*NCH-1:0] ctx_dbg;

   seq_det_sched #(.NCH(NCH), .CW(CW)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .bit_in  (bit_in),
      .ctx_clr (ctx_clr),
      .cnt_clr (cnt_clr),
      .cnt_sel (cnt_sel),
      .gnt     (gnt),
      .match   (match),
      .cnt_out (cnt_out),
      .ctx_dbg (ctx_dbg)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // ---------------- reference model ----------------
   // Detector behaviour as a lookup table: next context indexed by
   // [context][bit]; a match is reported for (S1,0) and (S2,1).
   int nxt_tab [4][2] = '{'{2, 3}, '{2, 3}, '{0, 3}, '{2, 1}};

   function automatic bit fires(input int s, input int b);
      return ((s == 1) && (b == 0)) || ((s == 2) && (b == 1));
   endfunction

   int m_ctx [NCH];
   int m_cnt [NCH];
   int m_last;

   // Scoreboard entries: {cycle at which the pulse is visible, match vector}.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   logic [NCH-1:0] seen_gnt;

   task automatic model_reset();
      m_last = NCH - 1;
      for (int i = 0; i < NCH; i++) begin
         m_ctx[i] = 0;
         m_cnt[i] = 0;
      end
      exp_q.delete();
   endtask

   function automatic logic [2*NCH-1:0] model_ctx_vec();
      logic [2*NCH-1:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[2*i +: 2] = 2'(m_ctx[i]);
      return v;
   endfunction

   // ---------------- driver ----------------
   // Drives one cycle of stimulus (called at posedge+1), checks the
   // combinational outputs and visible state at the falling edge, advances
   // the model across the rising edge and queues any expected match pulse.
   task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                       input logic [NCH-1:0] cc, input logic cclr,
                       input logic [SW-1:0] sel);
      int g;
      int s;
      int bb;
      logic [NCH-1:0] eg;
      logic [NCH-1:0] mv;
      req = r; bit_in = b; ctx_clr = cc; cnt_clr = cclr; cnt_sel = sel;
      @(negedge clk);
      g = -1;
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (m_last + k) % NCH;
         if (g < 0 && r[c] && !cc[c]) g = c;
      end
      eg = (g >= 0) ? (NCH'(1) << g) : '0;
      seen_gnt = gnt;
      chk("gnt", 64'(gnt), 64'(eg));
      chk("cnt_out", 64'(cnt_out), 64'(m_cnt[int'(sel)]));
      chk("ctx", 64'(ctx_dbg), 64'(model_ctx_vec()));
      mv = '0;
      for (int ch = 0; ch < NCH; ch++) if (cc[ch]) m_ctx[ch] = 0;
      if (g >= 0) begin
         s  = m_ctx[g];
         bb = int'(b[g]);
         if (fires(s, bb)) begin
            mv[g] = 1'b1;
            if (m_cnt[g] < CMAX) m_cnt[g]++;
         end
         m_ctx[g] = nxt_tab[s][bb];
         m_last   = g;
      end
      if (cclr) for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
      if (mv != '0) exp_q.push_back({32'(cyc + 1), mv});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [SW-1:0] sel);
      step('0, '0, '0, 1'b0, sel);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = '0; bit_in = '0; ctx_clr = '0; cnt_clr = 1'b0; cnt_sel = '0;
      #1;
      chk("rst_match", 64'(match), 64'(0));
      chk("rst_ctx", 64'(ctx_dbg), 64'(0));
      chk("rst_cnt", 64'(cnt_out), 64'(0));
      chk("rst_gnt", 64'(gnt), 64'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && match !== '0) begin
         if (exp_q.size() == 0) begin
            chk("match_unexpected", 64'(match), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            chk("match_vec", 64'(match), 64'(mon_e[NCH-1:0]));
            chk("match_cycle", 64'(cyc), 64'(mon_e[W-1:NCH]));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [NCH-1:0] exp_t3 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      reset = 1'b0;
      req = '0; bit_in = '0; ctx_clr = '0; cnt_clr = 1'b0; cnt_sel = '0;
      #1;

      // Test 1: ch0 sends 0,1
      do_reset();
      step(4'b0001, 4'b0000, '0, 1'b0, 2'd0);
      step(4'b0001, 4'b0001, '0, 1'b0, 2'd0);
      idle(2'd0);
      chk("t1_ctx0", 64'(ctx_dbg[1:0]), 64'(3));
      chk("t1_cnt0", 64'(cnt_out), 64'(1));

      // Test 2: ch1 sends 1,1,0
      do_reset();
      step(4'b0010, 4'b0010, '0, 1'b0, 2'd1);
      step(4'b0010, 4'b0010, '0, 1'b0, 2'd1);
      step(4'b0010, 4'b0000, '0, 1'b0, 2'd1);
      idle(2'd1);
      chk("t2_ctx1", 64'(ctx_dbg[3:2]), 64'(2));
      chk("t2_ctx_others", 64'({ctx_dbg[7:4], ctx_dbg[1:0]}), 64'(0));

      // Test 3: all channels requesting from reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 4'($urandom_range(0, 15)), '0, 1'b0, 2'd0);
         chk("t3_rr", 64'(seen_gnt), 64'(exp_t3[i]));
      end

      // Test 4: interleaved ch0 / ch2
      do_reset();
      step(4'b0101, 4'b0000, '0, 1'b0, 2'd0);
      step(4'b0100, 4'b0000, '0, 1'b0, 2'd0);
      step(4'b0001, 4'b0001, '0, 1'b0, 2'd0);
      step(4'b0100, 4'b0100, '0, 1'b0, 2'd2);
      idle(2'd2);
      chk("t4_ctx0", 64'(ctx_dbg[1:0]), 64'(3));
      chk("t4_ctx2", 64'(ctx_dbg[5:4]), 64'(3));
      chk("t4_cnt2", 64'(cnt_out), 64'(1));

      // Test 5: saturation on ch3, then clear coincident with a match
      do_reset();
      for (int i = 0; i < 700; i++) begin
         step(4'b1000, (i % 2 == 1) ? 4'b1000 : 4'b0000, '0, 1'b0, 2'd3);
      end
      chk("t5_sat", 64'(cnt_out), 64'(255));
      step(4'b1000, 4'b0000, '0, 1'b0, 2'd3);
      step(4'b1000, 4'b1000, '0, 1'b1, 2'd3);
      idle(2'd3);
      chk("t5_clr", 64'(cnt_out), 64'(0));

      // Test 6: context clear masks the channel, then reset mid-stream
      do_reset();
      step(4'b0001, 4'b0001, '0, 1'b0, 2'd0);
      step(4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
      chk("t6_masked", 64'(seen_gnt), 64'(0));
      idle(2'd0);
      chk("t6_ctx0", 64'(ctx_dbg[1:0]), 64'(0));
      step(4'b0001, 4'b0000, '0, 1'b0, 2'd0);
      step(4'b0001, 4'b0001, '0, 1'b0, 2'd0);
      req = 4'b1010; bit_in = '0; cnt_sel = 2'd0;
      reset = 1'b1;
      #1;
      chk("t6_rst_match", 64'(match), 64'(0));
      chk("t6_rst_ctx", 64'(ctx_dbg), 64'(0));
      chk("t6_rst_cnt", 64'(cnt_out), 64'(0));
      chk("t6_rst_gnt", 64'(gnt), 64'(4'b0010));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step(4'b1010, 4'b0000, '0, 1'b0, 2'd0);
      chk("t6_first_gnt", 64'(seen_gnt), 64'(4'b0010));

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
              ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
      end

      idle(2'd0);
      idle(2'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
